kmeans_centroid_update_k3_d2: RTL and testbench
===============================================

// Module: kmeans_centroid_update_k3_d2
// PURPOSE
//  Consumer end of the k=3, d=2 assignment pipeline: takes each (point, selected_centroid) result and accumulates
//  per-centroid sums and counts over one epoch, then divides to produce the new centroids.
//  New centroids are presented to the assignment pipeline's centroid inputs for the next epoch.
// PARAMETERS
//  input_data_width   16  unsigned width of each point/centroid coordinate
//  centroid_id_width  2   width of centroid index (values 0..2 valid, 3 ignored)
//  count_width        16  per-centroid point counter width; acc width = input_data_width+count_width (localparam)
// PORTS
//  clk                input   1    clock, all logic rising-edge
//  rst                input   1    synchronous, active-high reset
//  load               input   1    IDLE only: write input_data0/1 into centroid[selected_centroid] (initial seeds)
//  start              input   1    IDLE only: clear sums/counts, enter ACCUM
//  in_valid           input   1    ACCUM only: input_data0/1 + selected_centroid valid this cycle
//  in_last            input   1    qualifies in_valid: final point of epoch
//  input_data0/1      input   input_data_width   point coordinates d0/d1
//  selected_centroid  input   centroid_id_width  winning centroid for the point
//  centroidK_dD       output  input_data_width   (K=0..2, D=0..1) registered current centroids, 6 ports
//  busy               output  1    high in ACCUM and DIVIDE
//  out_valid          output  1    one-cycle pulse: centroid outputs just updated
//  converged          output  1    see CONFIGURATION
// BEHAVIOUR
//  Reset: all centroid outputs 0, sums/counts 0, busy 0, out_valid 0, converged 0, state IDLE.
//  FSM: IDLE -start-> ACCUM -(in_valid&in_last)-> DIVIDE -(6th quotient done)-> DONE -> IDLE.
//  IDLE: load writes one centroid per cycle (index 3 ignored); load and start together: load applied, start taken.
//  ACCUM: per valid point sum[sel][d] += input_data_d, count[sel] += 1; index 3 dropped (but in_last still ends epoch).
//  Count saturation: when count[sel] == 2^count_width-1, point dropped entirely (sum and count unchanged).
//  start/load outside IDLE ignored; in_valid outside ACCUM ignored.
//  DIVIDE: 6 unsigned divisions in order k0d0,k0d1,k1d0,k1d1,k2d0,k2d1, each exactly acc_width+1 cycles
//   (1 load + acc_width restoring iterations); fixed latency 6*(acc_width+1) cycles (=198 at defaults), no early exit.
//  Quotient truncated (floor); mean of unsigned input_data_width values always fits, no saturation needed.
//  count==0: division slot still consumed, centroid keeps previous value (no divide-by-zero result used).
//  DONE: all 6 centroid registers updated simultaneously, out_valid=1 this cycle only, busy=0.
//  rst mid-epoch or mid-divide: abort immediately, all state to reset values, no out_valid.
// CONFIGURATION
//  KMEANS_CU_CONVERGE_EN defined: converged registered with out_valid, 1 iff all six new centroids equal
//   previous values; held until next out_valid or rst.
//  Not defined: converged tied 0, no compare logic.
// STRUCTURE
//  Package kmeans_pkg: K=3, D=2 constants, width localparams, FSM state encoding (IDLE/ACCUM/DIVIDE/DONE).
//  Sub-module kmeans_serial_divider: start/done handshake, dividend acc_width, divisor count_width,
//   quotient acc_width (truncated by parent); one instance shared across the 6 divisions.
// TESTING
//  Seed via load c0=(0,0),c1=(100,100),c2=(200,200); start; points (10,20)->0,(30,40)->0,(90,110)->1 last
//   -> out_valid once, 198 cycles after last; c0=(20,30), c1=(90,110), c2=(200,200) unchanged (count 0).
//  Point with selected_centroid=3 plus in_last -> ignored in sums, epoch still closes, all centroids unchanged.
//  Floor check: points (1,2),(2,2) to c1 -> c1=(1,2).
//  rst asserted 50 cycles into DIVIDE -> busy=0, out_valid never pulses, centroids read 0.
//  start/load during ACCUM/DIVIDE -> no effect; in_valid in IDLE -> sums stay 0.
//  KMEANS_CU_CONVERGE_EN: repeat identical epoch twice -> converged 0 then 1; macro off -> converged always 0.

Source files
------------

// File: rtl/kmeans_pkg.sv
// Shared constants and FSM encoding for the k=3, d=2 centroid update block.
package kmeans_pkg;

    localparam int K                 = 3;
    localparam int D                 = 2;
    localparam int NUM_SLOTS         = K * D;
    localparam int INPUT_DATA_WIDTH  = 16;
    localparam int CENTROID_ID_WIDTH = 2;
    localparam int COUNT_WIDTH       = 16;
    localparam int ACC_WIDTH         = INPUT_DATA_WIDTH + COUNT_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_DIVIDE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/kmeans_serial_divider.sv
// Restoring serial divider: one load cycle followed by acc_width iterations.
// done is asserted during the final iteration and quotient carries the value
// being written on that edge, so the caller can capture it with no extra cycle.
module kmeans_serial_divider #(
    parameter int acc_width   = 32,
    parameter int count_width = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [acc_width-1:0]   dividend,
    input  logic [count_width-1:0] divisor,
    output logic                   busy,
    output logic                   done,
    output logic [acc_width-1:0]   quotient
);

    localparam int CNT_W = $clog2(acc_width + 1);

    logic [CNT_W-1:0]       iter_q, iter_d;
    logic [acc_width-1:0]   quo_q, quo_d;
    logic [count_width-1:0] rem_q, rem_d;
    logic [count_width-1:0] dvs_q, dvs_d;
    logic [count_width:0]   shifted;
    logic [count_width:0]   trial;
    logic                   ge;

    // One restoring step per cycle; start overrides and reloads the operands.
    always_comb begin
        iter_d  = iter_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        shifted = {rem_q, quo_q[acc_width-1]};
        ge      = (shifted >= {1'b0, dvs_q});
        trial   = shifted - {1'b0, dvs_q};
        if (start) begin
            iter_d = CNT_W'(acc_width);
            quo_d  = dividend;
            rem_d  = '0;
            dvs_d  = divisor;
        end else if (iter_q != '0) begin
            iter_d = iter_q - CNT_W'(1);
            quo_d  = {quo_q[acc_width-2:0], ge};
            rem_d  = ge ? trial[count_width-1:0] : shifted[count_width-1:0];
        end
    end

    // Divider state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            iter_q <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
        end else begin
            iter_q <= iter_d;
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
        end
    end

    // Handshake outputs.
    always_comb begin
        busy     = (iter_q != '0);
        done     = (iter_q == CNT_W'(1));
        quotient = quo_d;
    end

endmodule

// File: rtl/kmeans_centroid_update_k3_d2.sv
// k-means centroid update (k=3, d=2): accumulates per-centroid sums/counts over
// an epoch, then divides serially (one shared divider, six slots) and publishes
// all new centroids at once. Optional feature macro: KMEANS_CU_CONVERGE_EN
// (registered "no centroid moved" flag).
module kmeans_centroid_update_k3_d2
    import kmeans_pkg::*;
#(
    parameter int input_data_width  = INPUT_DATA_WIDTH,
    parameter int centroid_id_width = CENTROID_ID_WIDTH,
    parameter int count_width       = COUNT_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load,
    input  logic                         start,
    input  logic                         in_valid,
    input  logic                         in_last,
    input  logic [input_data_width-1:0]  input_data0,
    input  logic [input_data_width-1:0]  input_data1,
    input  logic [centroid_id_width-1:0] selected_centroid,
    output logic [input_data_width-1:0]  centroid0_d0,
    output logic [input_data_width-1:0]  centroid0_d1,
    output logic [input_data_width-1:0]  centroid1_d0,
    output logic [input_data_width-1:0]  centroid1_d1,
    output logic [input_data_width-1:0]  centroid2_d0,
    output logic [input_data_width-1:0]  centroid2_d1,
    output logic                         busy,
    output logic                         out_valid,
    output logic                         converged
);

    localparam int acc_width = input_data_width + count_width;

    // Slot index = 2*k + d throughout.
    state_e                                      state_q, state_d;
    logic [NUM_SLOTS-1:0][acc_width-1:0]         sum_q, sum_d;
    logic [K-1:0][count_width-1:0]               count_q, count_d;
    logic [NUM_SLOTS-1:0][input_data_width-1:0]  cent_q, cent_d;
    logic [NUM_SLOTS-1:0][input_data_width-1:0]  new_q, new_d;
    logic [NUM_SLOTS-1:0][input_data_width-1:0]  fin;
    logic [2:0]                                  slot_q, slot_d;
    logic                                        sel_ok;
    logic                                        div_start, div_busy, div_done;
    logic [acc_width-1:0]                        div_quotient;
    logic [input_data_width-1:0]                 slot_val;

    kmeans_serial_divider #(
        .acc_width   (acc_width),
        .count_width (count_width)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (sum_q[slot_q]),
        .divisor  (count_q[slot_q[2:1]]),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quotient)
    );

    // Result for the active slot: empty clusters keep their previous centroid.
    always_comb begin
        div_start = (state_q == ST_DIVIDE) && !div_busy;
        sel_ok    = (selected_centroid < centroid_id_width'(K));
        slot_val  = (count_q[slot_q[2:1]] == '0) ? cent_q[slot_q]
                                                 : div_quotient[input_data_width-1:0];
    end

    // Staged results, with the slot finishing this cycle merged in.
    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_fin
            assign fin[gi] = (div_done && slot_q == 3'(gi)) ? slot_val : new_q[gi];
        end
    endgenerate

`ifdef KMEANS_CU_CONVERGE_EN
    logic conv_q, conv_d;
`endif

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        count_d = count_q;
        cent_d  = cent_q;
        new_d   = new_q;
        slot_d  = slot_q;
`ifdef KMEANS_CU_CONVERGE_EN
        conv_d  = conv_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (load && sel_ok) begin
                    cent_d[{selected_centroid, 1'b0}] = input_data0;
                    cent_d[{selected_centroid, 1'b1}] = input_data1;
                end
                if (start) begin
                    sum_d   = '0;
                    count_d = '0;
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (in_valid) begin
                    if (sel_ok && count_q[selected_centroid] != '1) begin
                        sum_d[{selected_centroid, 1'b0}] = sum_q[{selected_centroid, 1'b0}]
                            + {{count_width{1'b0}}, input_data0};
                        sum_d[{selected_centroid, 1'b1}] = sum_q[{selected_centroid, 1'b1}]
                            + {{count_width{1'b0}}, input_data1};
                        count_d[selected_centroid] = count_q[selected_centroid]
                            + count_width'(1);
                    end
                    if (in_last) begin
                        slot_d  = '0;
                        state_d = ST_DIVIDE;
                    end
                end
            end
            ST_DIVIDE: begin
                if (div_done) begin
                    new_d  = fin;
                    slot_d = slot_q + 3'd1;
                    if (slot_q == 3'(NUM_SLOTS - 1)) begin
                        cent_d  = fin;
                        state_d = ST_DONE;
`ifdef KMEANS_CU_CONVERGE_EN
                        conv_d  = (fin == cent_q);
`endif
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sum_q   <= '0;
            count_q <= '0;
            cent_q  <= '0;
            new_q   <= '0;
            slot_q  <= '0;
`ifdef KMEANS_CU_CONVERGE_EN
            conv_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            count_q <= count_d;
            cent_q  <= cent_d;
            new_q   <= new_d;
            slot_q  <= slot_d;
`ifdef KMEANS_CU_CONVERGE_EN
            conv_q  <= conv_d;
`endif
        end
    end

    // Outputs decoded from state and centroid registers.
    always_comb begin
        busy         = (state_q == ST_ACCUM) || (state_q == ST_DIVIDE);
        out_valid    = (state_q == ST_DONE);
        centroid0_d0 = cent_q[0];
        centroid0_d1 = cent_q[1];
        centroid1_d0 = cent_q[2];
        centroid1_d1 = cent_q[3];
        centroid2_d0 = cent_q[4];
        centroid2_d1 = cent_q[5];
`ifdef KMEANS_CU_CONVERGE_EN
        converged    = conv_q;
`else
        converged    = 1'b0;
`endif
    end

endmodule

// File: tb/tb_kmeans_centroid_update_k3_d2.sv
// Self-checking bench for kmeans_centroid_update_k3_d2: a reference model
// pushes expected centroid sets when in_last is driven; a monitor pops and
// compares when out_valid pulses. Honours KMEANS_CU_CONVERGE_EN.
module tb_kmeans_centroid_update_k3_d2;

    typedef struct packed {
        logic             conv;
        logic [5:0][15:0] c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, load, start, in_valid, in_last;
    logic [15:0] input_data0, input_data1;
    logic [1:0]  selected_centroid;
    logic [15:0] c0d0, c0d1, c1d0, c1d1, c2d0, c2d1;
    logic        busy, out_valid, converged;
    logic [5:0][15:0] dut_c;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   last_cyc = 0;
    exp_t sb_q[$];

    int   m_cent[6];
    int   m_sum[6];
    int   m_cnt[3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    kmeans_centroid_update_k3_d2 dut (
        .clk               (clk),
        .rst               (rst),
        .load              (load),
        .start             (start),
        .in_valid          (in_valid),
        .in_last           (in_last),
        .input_data0       (input_data0),
        .input_data1       (input_data1),
        .selected_centroid (selected_centroid),
        .centroid0_d0      (c0d0),
        .centroid0_d1      (c0d1),
        .centroid1_d0      (c1d0),
        .centroid1_d1      (c1d1),
        .centroid2_d0      (c2d0),
        .centroid2_d1      (c2d1),
        .busy              (busy),
        .out_valid         (out_valid),
        .converged         (converged)
    );

    assign dut_c = {c2d1, c2d0, c1d1, c1d0, c0d1, c0d0};

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        load = 0; start = 0; in_valid = 0; in_last = 0;
        input_data0 = 0; input_data1 = 0; selected_centroid = 0;
    endtask

    task automatic load_c(input int k, input int x, input int y);
        @(negedge clk);
        idle_inputs();
        load = 1; selected_centroid = 2'(k);
        input_data0 = 16'(x); input_data1 = 16'(y);
        if (k < 3) begin
            m_cent[2*k] = x; m_cent[2*k+1] = y;
        end
        $display("load  k=%0d (%0d,%0d)", k, x, y);
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic start_epoch();
        @(negedge clk);
        idle_inputs();
        start = 1;
        for (int i = 0; i < 6; i++) m_sum[i] = 0;
        for (int i = 0; i < 3; i++) m_cnt[i] = 0;
        $display("start epoch");
        @(negedge clk);
        idle_inputs();
    endtask

    // Drives one point; on the last point computes and pushes the expected set.
    task automatic send_point(input int x, input int y, input int sel, input bit last);
        exp_t e;
        int   nv;
        @(negedge clk);
        idle_inputs();
        in_valid = 1; in_last = last;
        input_data0 = 16'(x); input_data1 = 16'(y); selected_centroid = 2'(sel);
        if (sel < 3) begin
            m_sum[2*sel] += x; m_sum[2*sel+1] += y; m_cnt[sel]++;
        end
        $display("point (%0d,%0d) -> %0d last=%0d", x, y, sel, last);
        if (last) begin
            last_cyc = cyc + 1;
            e.conv = 1'b1;
            for (int i = 0; i < 6; i++) begin
                nv = (m_cnt[i/2] == 0) ? m_cent[i] : m_sum[i] / m_cnt[i/2];
                if (nv != m_cent[i]) e.conv = 1'b0;
                e.c[i] = 16'(nv);
                m_cent[i] = nv;
            end
`ifndef KMEANS_CU_CONVERGE_EN
            e.conv = 1'b0;
`endif
            sb_q.push_back(e);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_eq("epoch_timeout", (sb_q.size() == 0) ? 1 : 0, 1);
        repeat (3) @(negedge clk);
    endtask

    // Scoreboard monitor: every out_valid must match a pending expectation.
    always @(negedge clk) begin
        exp_t e;
        if (out_valid) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_out_valid", 1, 0);
            end else begin
                e = sb_q.pop_front();
                for (int i = 0; i < 6; i++)
                    check_eq($sformatf("c%0d_d%0d", i/2, i%2), int'(dut_c[i]), int'(e.c[i]));
                check_eq("converged", int'(converged), int'(e.conv));
                check_eq("latency", cyc - last_cyc, 198);
                check_eq("busy_in_done", int'(busy), 0);
                $display("result c0=(%0d,%0d) c1=(%0d,%0d) c2=(%0d,%0d) conv=%0d",
                         c0d0, c0d1, c1d0, c1d1, c2d0, c2d1, converged);
            end
        end
    end

    initial begin
        idle_inputs();
        rst = 1;
        for (int i = 0; i < 6; i++) m_cent[i] = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        check_eq("rst_c0d0", int'(c0d0), 0);
        check_eq("rst_c2d1", int'(c2d1), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_out_valid", int'(out_valid), 0);
        check_eq("rst_converged", int'(converged), 0);

        // Seeds; index 3 load ignored.
        load_c(0, 0, 0);
        load_c(1, 100, 100);
        load_c(2, 200, 200);
        load_c(3, 777, 777);
        check_eq("seed_c1d0", int'(c1d0), 100);
        check_eq("seed_c2d1", int'(c2d1), 200);
        check_eq("seed_c0d0", int'(c0d0), 0);

        // Basic epoch.
        start_epoch();
        check_eq("busy_accum", int'(busy), 1);
        send_point(10, 20, 0, 0);
        send_point(30, 40, 0, 0);
        send_point(90, 110, 1, 1);
        check_eq("busy_divide", int'(busy), 1);
        wait_done();

        // Only an index-3 point, closing the epoch.
        start_epoch();
        send_point(5000, 6000, 3, 1);
        wait_done();

        // Floor check, then the identical epoch again.
        for (int r = 0; r < 2; r++) begin
            start_epoch();
            send_point(1, 2, 1, 0);
            send_point(2, 2, 1, 1);
            wait_done();
        end

        // start/load during ACCUM and DIVIDE have no effect.
        start_epoch();
        send_point(40, 60, 2, 0);
        @(negedge clk);
        start = 1; load = 1; selected_centroid = 0; input_data0 = 999; input_data1 = 999;
        @(negedge clk);
        idle_inputs();
        send_point(50, 70, 2, 1);
        repeat (20) @(negedge clk);
        start = 1; load = 1; in_valid = 1; in_last = 1;
        selected_centroid = 0; input_data0 = 888; input_data1 = 888;
        @(negedge clk);
        idle_inputs();
        wait_done();

        // in_valid/in_last in IDLE are ignored.
        @(negedge clk);
        in_valid = 1; in_last = 1; selected_centroid = 0; input_data0 = 500; input_data1 = 500;
        @(negedge clk);
        idle_inputs();
        check_eq("idle_in_valid_busy", int'(busy), 0);

        // Mixed random epoch.
        start_epoch();
        for (int i = 0; i < 12; i++)
            send_point(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
                       int'($urandom_range(0, 3)), i == 11);
        wait_done();

        // Reset 50 cycles into DIVIDE aborts the epoch.
        start_epoch();
        send_point(300, 400, 0, 1);
        repeat (50) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        sb_q.delete();
        for (int i = 0; i < 6; i++) m_cent[i] = 0;
        check_eq("abort_busy", int'(busy), 0);
        check_eq("abort_c1d0", int'(c1d0), 0);
        check_eq("abort_c2d0", int'(c2d0), 0);
        repeat (250) @(negedge clk);
        check_eq("abort_converged", int'(converged), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
